// File: rtl/aes_round_ctrl.sv
// Control sequencer for an iterative AES-128 core with one shared SubBytes stage.
// Drives only strobes and selects; the datapath holds the state and key.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  output logic       in_ready_o,
  output logic       state_load_o,
  output logic       state_sel_o,
  output logic       mix_en_o,
  output logic       key_load_o,
  output logic       key_step_o,
  output logic [7:0] rcon_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       out_valid_o,
  input  logic       out_ready_i
);

  // state | meaning
  // IDLE  | waiting for start_i
  // LOAD  | state <= plaintext^key, key schedule loaded
  // SUB   | SubBytes registers the state, key schedule steps
  // RND   | state <= round result (MixColumns skipped in the last round)
  // DONE  | ciphertext valid, waiting for out_ready_i
  typedef enum logic [2:0] {IDLE, LOAD, SUB, RND, DONE} state_e;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_e      state_q, state_d;
  logic [3:0]  round_q, round_d;
  logic [7:0]  rcon_q, rcon_d;
  logic        in_ready_q, in_ready_d;
  logic        state_load_q, state_load_d;
  logic        state_sel_q, state_sel_d;
  logic        mix_en_q, mix_en_d;
  logic        key_load_q, key_load_d;
  logic        key_step_q, key_step_d;
  logic        busy_q, busy_d;
  logic        out_valid_q, out_valid_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    case (state_q)
      IDLE: if (start_i) state_d = LOAD;
      LOAD: begin
        state_d = SUB;
        round_d = 4'd1;
        rcon_d  = 8'h01;
      end
      SUB:  state_d = RND;
      RND: begin
        if (round_q == LAST_ROUND) begin
          state_d = DONE;
        end else begin
          state_d = SUB;
          round_d = round_q + 4'd1;
          rcon_d  = xtime(rcon_q);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
          round_d = 4'd0;
          rcon_d  = 8'h01;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they land in flops aligned with state_q.
    in_ready_d   = 1'b0;
    state_load_d = 1'b0;
    state_sel_d  = 1'b0;
    mix_en_d     = 1'b1;
    key_load_d   = 1'b0;
    key_step_d   = 1'b0;
    busy_d       = 1'b0;
    out_valid_d  = 1'b0;
    case (state_d)
      IDLE: in_ready_d = 1'b1;
      LOAD: begin
        state_load_d = 1'b1;
        key_load_d   = 1'b1;
        busy_d       = 1'b1;
      end
      SUB: begin
        key_step_d = 1'b1;
        busy_d     = 1'b1;
      end
      RND: begin
        state_load_d = 1'b1;
        state_sel_d  = 1'b1;
        busy_d       = 1'b1;
        mix_en_d     = (round_d != LAST_ROUND);
      end
      DONE: out_valid_d = 1'b1;
      default: in_ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      round_q      <= 4'd0;
      rcon_q       <= 8'h01;
      in_ready_q   <= 1'b1;
      state_load_q <= 1'b0;
      state_sel_q  <= 1'b0;
      mix_en_q     <= 1'b1;
      key_load_q   <= 1'b0;
      key_step_q   <= 1'b0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      rcon_q       <= rcon_d;
      in_ready_q   <= in_ready_d;
      state_load_q <= state_load_d;
      state_sel_q  <= state_sel_d;
      mix_en_q     <= mix_en_d;
      key_load_q   <= key_load_d;
      key_step_q   <= key_step_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign state_load_o = state_load_q;
  assign state_sel_o  = state_sel_q;
  assign mix_en_o     = mix_en_q;
  assign key_load_o   = key_load_q;
  assign key_step_o   = key_step_q;
  assign rcon_o       = rcon_q;
  assign round_o      = round_q;
  assign busy_o       = busy_q;
  assign out_valid_o  = out_valid_q;

endmodule
